data_mem_p: RTL and testbench

DATA_MEM_P -- requirements
Module: data_mem_p

---
 rtl/data_mem_p.sv | 117 +++++++++++
 tb/tb_data_mem_p.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_p.sv
// data_mem_p: single-port word memory with byte-enabled writes, one-cycle
// registered reads, and a self-initialising INIT phase that fills every word
// with INIT_VAL after reset before requests are accepted.
module data_mem_p #(
    parameter int unsigned   DW       = 16,
    parameter int unsigned   AW       = 8,
    parameter int unsigned   DEPTH    = 256,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [DW/8-1:0]   be,
    input  logic [AW-1:0]     addr,
    input  logic [DW-1:0]     wdata,
    output logic              ready,
    output logic [DW-1:0]     rdata,
    output logic              rvalid,
    output logic              err
);

    localparam int unsigned   NB      = DW / 8;
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_icnt;
    logic [DW-1:0] r_mem [DEPTH];

    logic          w_last;
    logic          w_accept;
    logic          w_in_range;
    logic [DW-1:0] w_merged;

    assign w_last     = (r_icnt == LAST);
    assign w_in_range = ({1'b0, addr} < DEPTH_W);
    assign w_accept   = req && ready;

    // State register; asynchronous active-low reset returns to INIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and ready: INIT until the last word is written, then RUN.
    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        case (r_state)
            S_INIT: begin
                if (w_last) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                ready = 1'b1;
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    // Initialisation word counter, walks 0..DEPTH-1 during INIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_icnt <= '0;
        end else if (r_state == S_INIT) begin
            r_icnt <= w_last ? '0 : r_icnt + 1'b1;
        end
    end

    // Merge write data into the current word under the byte enables.
    always_comb begin
        w_merged = r_mem[addr];
        for (int unsigned i = 0; i < NB; i++) begin
            if (be[i]) begin
                w_merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    // Memory array: filled during INIT, byte-enabled writes in RUN; no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            r_mem[r_icnt] <= INIT_VAL;
        end else if (w_accept && we && w_in_range) begin
            r_mem[addr] <= w_merged;
        end
    end

    // Registered read data plus one-cycle rvalid/err pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            rvalid <= w_accept && !we;
            err    <= w_accept && !w_in_range;
            if (w_accept && !we) begin
                rdata <= w_in_range ? r_mem[addr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_p.sv
// Directed testbench for data_mem_p: three instances (defaults, DEPTH=200,
// INIT_VAL=16'h0018) share one stimulus bus and reset.
module tb_data_mem_p;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  be;
    logic [7:0]  addr;
    logic [15:0] wdata;

    logic        a_ready, a_rvalid, a_err;
    logic [15:0] a_rdata;
    logic        b_ready, b_rvalid, b_err;
    logic [15:0] b_rdata;
    logic        c_ready, c_rvalid, c_err;
    logic [15:0] c_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    data_mem_p #(.DW(16), .AW(8), .DEPTH(256), .INIT_VAL(16'h0000)) u_a (
        .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
        .ready(a_ready), .rdata(a_rdata), .rvalid(a_rvalid), .err(a_err)
    );

    data_mem_p #(.DW(16), .AW(8), .DEPTH(200), .INIT_VAL(16'h0000)) u_b (
        .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
        .ready(b_ready), .rdata(b_rdata), .rvalid(b_rvalid), .err(b_err)
    );

    data_mem_p #(.DW(16), .AW(8), .DEPTH(256), .INIT_VAL(16'h0018)) u_c (
        .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
        .ready(c_ready), .rdata(c_rdata), .rvalid(c_rvalid), .err(c_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [1:0] b,
                         input logic [7:0] a, input logic [15:0] d);
        req   = r;
        we    = w;
        be    = b;
        addr  = a;
        wdata = d;
    endtask

    logic saw_ready;
    logic saw_rvalid;

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
        #2 rst = 1'b0;
        tick(); tick(); tick();

        // Reset state
        chk("rst_ready",  a_ready,  0);
        chk("rst_rvalid", a_rvalid, 0);
        chk("rst_err",    a_err,    0);
        chk("rst_rdata",  a_rdata,  0);
        chk("rst_ready_b", b_ready, 0);
        chk("rst_ready_c", c_ready, 0);

        // Reset asserted at INIT cycle 100 with req held high
        drive(1'b1, 1'b0, 2'b00, 8'h00, 16'h0000);
        rst = 1'b1;
        saw_rvalid = a_rvalid;
        for (int k = 1; k <= 100; k++) begin
            tick();
            saw_rvalid = saw_rvalid | a_rvalid;
        end
        chk("midinit_rvalid_seen", saw_rvalid, 0);
        rst = 1'b0;
        #1;
        chk("midinit_rst_ready",  a_ready,  0);
        chk("midinit_rst_rvalid", a_rvalid, 0);
        chk("midinit_rst_err",    a_err,    0);
        chk("midinit_rst_rdata",  a_rdata,  0);
        tick();

        // Full INIT rerun: ready low for 256 cycles, high on cycle 257
        rst = 1'b1;
        saw_ready  = a_ready;
        saw_rvalid = a_rvalid;
        for (int k = 1; k <= 255; k++) begin
            tick();
            saw_ready  = saw_ready | a_ready;
            saw_rvalid = saw_rvalid | a_rvalid;
        end
        chk("init_ready_low",   saw_ready,  0);
        chk("init_rvalid_none", saw_rvalid, 0);
        tick();
        chk("ready_cycle257", a_ready, 1);
        chk("ready_c_run",    c_ready, 1);
        chk("ready_b_run",    b_ready, 1);

        // Back-to-back reads of 0, 128, 255 (req=1, addr=0 already driven)
        tick();
        chk("rd0_rvalid", a_rvalid, 1);
        chk("rd0_rdata",  a_rdata,  16'h0000);
        chk("rd0_c_rdata", c_rdata, 16'h0018);
        addr = 8'd128;
        tick();
        chk("rd128_rvalid", a_rvalid, 1);
        chk("rd128_rdata",  a_rdata,  16'h0000);
        chk("rd128_c_rdata", c_rdata, 16'h0018);
        addr = 8'd255;
        tick();
        chk("rd255_rvalid", a_rvalid, 1);
        chk("rd255_err",    a_err,    0);
        chk("rd255_rdata",  a_rdata,  16'h0000);
        chk("rd255_c_rdata", c_rdata, 16'h0018);
        req = 1'b0;
        tick();
        chk("idle_rvalid",  c_rvalid, 0);
        chk("idle_c_hold",  c_rdata,  16'h0018);

        // Byte-enabled writes to 0x10 then read
        drive(1'b1, 1'b1, 2'b11, 8'h10, 16'hA5C3);
        tick();
        chk("wr_no_rvalid", a_rvalid, 0);
        chk("wr_no_err",    a_err,    0);
        drive(1'b1, 1'b1, 2'b01, 8'h10, 16'hFFFF);
        tick();
        drive(1'b1, 1'b0, 2'b00, 8'h10, 16'h0000);
        tick();
        chk("be01_rvalid", a_rvalid, 1);
        chk("be01_rdata",  a_rdata,  16'hA5FF);
        req = 1'b0;
        tick();
        chk("hold_rvalid", a_rvalid, 0);
        chk("hold_rdata",  a_rdata,  16'hA5FF);

        // be=0 write leaves the word unchanged
        drive(1'b1, 1'b1, 2'b00, 8'h10, 16'h0000);
        tick();
        drive(1'b1, 1'b0, 2'b00, 8'h10, 16'h0000);
        tick();
        chk("be00_rdata", a_rdata, 16'hA5FF);

        // Write then read same address on the next cycle, no bubble
        drive(1'b1, 1'b1, 2'b11, 8'h05, 16'h1234);
        tick();
        drive(1'b1, 1'b0, 2'b00, 8'h05, 16'h0000);
        tick();
        chk("raw_rvalid", a_rvalid, 1);
        chk("raw_rdata",  a_rdata,  16'h1234);
        drive(1'b1, 1'b1, 2'b10, 8'h05, 16'hAB00);
        tick();
        drive(1'b1, 1'b0, 2'b00, 8'h05, 16'h0000);
        tick();
        chk("be10_rdata", a_rdata, 16'hAB34);

        // Out-of-range on DEPTH=200 instance
        drive(1'b1, 1'b1, 2'b11, 8'd200, 16'hBEEF);
        tick();
        chk("oor_wr_err_b",    b_err,    1);
        chk("oor_wr_rvalid_b", b_rvalid, 0);
        chk("inr_wr_err_a",    a_err,    0);
        drive(1'b1, 1'b0, 2'b00, 8'd200, 16'h0000);
        tick();
        chk("oor_rd_err_b",    b_err,    1);
        chk("oor_rd_rvalid_b", b_rvalid, 1);
        chk("oor_rd_rdata_b",  b_rdata,  16'h0000);
        chk("inr_rd_rdata_a",  a_rdata,  16'hBEEF);
        addr = 8'd199;
        tick();
        chk("rd199_err_b",    b_err,    0);
        chk("rd199_rvalid_b", b_rvalid, 1);
        chk("rd199_rdata_b",  b_rdata,  16'h0000);
        chk("rd199_rdata_c",  c_rdata,  16'h0018);
        req = 1'b0;
        tick();
        chk("idle_err_b",    b_err,    0);
        chk("idle_rvalid_b", b_rvalid, 0);

        // Asynchronous reset in the middle of an access
        drive(1'b1, 1'b0, 2'b00, 8'h10, 16'h0000);
        tick();
        chk("pre_rst_rdata", a_rdata, 16'hA5FF);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_rdata",  a_rdata,  16'h0000);
        chk("async_rst_rvalid", a_rvalid, 0);
        chk("async_rst_ready",  a_ready,  0);
        tick();
        chk("pending_discard", a_rvalid, 0);
        req = 1'b0;
        rst = 1'b1;
        for (int k = 1; k <= 255; k++) tick();
        chk("reinit_ready_255", a_ready, 0);
        tick();
        chk("reinit_ready_256", a_ready, 1);

        // Memory re-initialised after reset
        drive(1'b1, 1'b0, 2'b00, 8'h10, 16'h0000);
        tick();
        chk("reinit_rdata_c", c_rdata, 16'h0018);
        chk("reinit_rdata_a", a_rdata, 16'h0000);
        chk("reinit_rvalid",  a_rvalid, 1);
        req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
